// File: rtl/control_seq.sv
// Microcoded T-state sequencer for the 8-bit bus computer: decodes {T-state, opcode, flags}
// into bus strobes. Optional macro CU_EARLY_RETURN_EN shortens instructions with empty tails.
module control_seq #(
   parameter int TSTATES = 5
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] opcode,
   input  logic       cf,
   input  logic       zf,
   output logic       pcoe,
   output logic       pcjmp,
   output logic       pcinc,
   output logic       marwa,
   output logic       ramoa,
   output logic       ramwa,
   output logic       inregwa,
   output logic       inregoa,
   output logic       awa,
   output logic       aoa,
   output logic       bwa,
   output logic       boa,
   output logic       sumout,
   output logic       sub,
   output logic       flagsin,
   output logic       outregwa,
   output logic       halt,
   output logic [2:0] tstate
);

   generate
      if (TSTATES != 5) begin : g_bad_tstates
         $error("control_seq: TSTATES must be 5");
      end
   endgenerate

   localparam logic [2:0] T_LAST = 3'(TSTATES - 1);

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   logic [2:0] r_t;
   logic       r_halted;
   logic       r_run;
   logic [2:0] w_t_nxt;
   logic       w_halted_nxt;
   logic       w_done;

   // r_run stays low through reset so outputs are silent until the first edge after release
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_t      <= 3'd0;
         r_halted <= 1'b0;
         r_run    <= 1'b0;
      end else begin
         r_t      <= w_t_nxt;
         r_halted <= w_halted_nxt;
         r_run    <= 1'b1;
      end
   end

   always_comb begin
      w_t_nxt      = r_t;
      w_halted_nxt = r_halted;
      w_done       = 1'b0;
`ifdef CU_EARLY_RETURN_EN
      case (r_t)
         3'd2:    w_done = !((opcode == OP_LDA) || (opcode == OP_ADD) ||
                             (opcode == OP_SUB) || (opcode == OP_STA));
         3'd3:    w_done = (opcode == OP_LDA) || (opcode == OP_STA);
         default: w_done = 1'b0;
      endcase
`endif
      if (r_run && !r_halted) begin
         if ((r_t == 3'd2) && (opcode == OP_HLT)) begin
            w_halted_nxt = 1'b1;
         end else if ((r_t == T_LAST) || w_done) begin
            w_t_nxt = 3'd0;
         end else begin
            w_t_nxt = r_t + 3'd1;
         end
      end
   end

   always_comb begin
      pcoe     = 1'b0;
      pcjmp    = 1'b0;
      pcinc    = 1'b0;
      marwa    = 1'b0;
      ramoa    = 1'b0;
      ramwa    = 1'b0;
      inregwa  = 1'b0;
      inregoa  = 1'b0;
      awa      = 1'b0;
      aoa      = 1'b0;
      bwa      = 1'b0;
      boa      = 1'b0;
      sumout   = 1'b0;
      sub      = 1'b0;
      flagsin  = 1'b0;
      outregwa = 1'b0;
      halt     = r_halted;
      tstate   = r_t;
      if (r_run && !r_halted) begin
         case (r_t)
            3'd0: begin
               pcoe  = 1'b1;
               marwa = 1'b1;
            end
            3'd1: begin
               ramoa   = 1'b1;
               inregwa = 1'b1;
               pcinc   = 1'b1;
            end
            3'd2: begin
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     inregoa = 1'b1;
                     marwa   = 1'b1;
                  end
                  OP_LDI: begin
                     inregoa = 1'b1;
                     awa     = 1'b1;
                  end
                  OP_JMP: begin
                     inregoa = 1'b1;
                     pcjmp   = 1'b1;
                  end
                  OP_JC: begin
                     inregoa = cf;
                     pcjmp   = cf;
                  end
                  OP_JZ: begin
                     inregoa = zf;
                     pcjmp   = zf;
                  end
                  OP_OUT: begin
                     aoa      = 1'b1;
                     outregwa = 1'b1;
                  end
                  default: ;
               endcase
            end
            3'd3: begin
               case (opcode)
                  OP_LDA: begin
                     ramoa = 1'b1;
                     awa   = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     ramoa = 1'b1;
                     bwa   = 1'b1;
                  end
                  OP_STA: begin
                     aoa   = 1'b1;
                     ramwa = 1'b1;
                  end
                  default: ;
               endcase
            end
            3'd4: begin
               if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                  sumout  = 1'b1;
                  awa     = 1'b1;
                  flagsin = 1'b1;
                  sub     = (opcode == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_seq.sv
// Bench for control_seq: a small bus/RAM/register model follows the strobes, and a
// scoreboard queue holds the expected strobe word for each upcoming cycle.
module tb_control_seq;

   localparam logic [15:0] PCOE     = 16'h8000;
   localparam logic [15:0] PCJMP    = 16'h4000;
   localparam logic [15:0] PCINC    = 16'h2000;
   localparam logic [15:0] MARWA    = 16'h1000;
   localparam logic [15:0] RAMOA    = 16'h0800;
   localparam logic [15:0] RAMWA    = 16'h0400;
   localparam logic [15:0] INREGWA  = 16'h0200;
   localparam logic [15:0] INREGOA  = 16'h0100;
   localparam logic [15:0] AWA      = 16'h0080;
   localparam logic [15:0] AOA      = 16'h0040;
   localparam logic [15:0] BWA      = 16'h0020;
   localparam logic [15:0] BOA      = 16'h0010;
   localparam logic [15:0] SUMOUT   = 16'h0008;
   localparam logic [15:0] SUB      = 16'h0004;
   localparam logic [15:0] FLAGSIN  = 16'h0002;
   localparam logic [15:0] OUTREGWA = 16'h0001;

   logic       clk = 1'b0;
   logic       clr;
   logic [3:0] opcode;
   logic       cf, zf;
   logic       pcoe, pcjmp, pcinc, marwa, ramoa, ramwa, inregwa, inregoa;
   logic       awa, aoa, bwa, boa, sumout, sub, flagsin, outregwa, halt;
   logic [2:0] tstate;
   logic [15:0] strobes;

   int checks   = 0;
   int failures = 0;

   // program: LDA e, ADD f, OUT, JC 6, JC 3, -, HLT, ADD e, NOP ; data e=0x38 f=0x23
   logic [7:0] ram [16] = '{8'h1E, 8'h2F, 8'hE0, 8'h76, 8'h73, 8'h00, 8'hF0, 8'h2E,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h38, 8'h23};
   logic [3:0] pc   = 4'h0;
   logic [3:0] mar  = 4'h0;
   logic [7:0] ir   = 8'h00;
   logic [7:0] a    = 8'h00;
   logic [7:0] b    = 8'h00;
   logic [7:0] outr = 8'h00;
   logic       use_rnd;
   logic [3:0] rnd_op;

   typedef struct {
      logic [19:0] v;
      string       tag;
   } exp_t;
   exp_t sb[$];

   assign opcode  = use_rnd ? rnd_op : ir[7:4];
   assign strobes = {pcoe, pcjmp, pcinc, marwa, ramoa, ramwa, inregwa, inregoa,
                     awa, aoa, bwa, boa, sumout, sub, flagsin, outregwa};

   control_seq #(.TSTATES(5)) dut (
      .clk(clk), .clr(clr), .opcode(opcode), .cf(cf), .zf(zf),
      .pcoe(pcoe), .pcjmp(pcjmp), .pcinc(pcinc), .marwa(marwa),
      .ramoa(ramoa), .ramwa(ramwa), .inregwa(inregwa), .inregoa(inregoa),
      .awa(awa), .aoa(aoa), .bwa(bwa), .boa(boa), .sumout(sumout), .sub(sub),
      .flagsin(flagsin), .outregwa(outregwa), .halt(halt), .tstate(tstate)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin : bus_model
      logic [7:0] bus;
      logic [7:0] alu;
      alu = sub ? (a - b) : (a + b);
      bus = 8'h00;
      if (pcoe)         bus = {4'h0, pc};
      else if (ramoa)   bus = ram[mar];
      else if (inregoa) bus = {4'h0, ir[3:0]};
      else if (aoa)     bus = a;
      else if (boa)     bus = b;
      else if (sumout)  bus = alu;
      if (marwa)    mar <= bus[3:0];
      if (ramwa)    ram[mar] <= bus;
      if (inregwa)  ir <= bus;
      if (awa)      a <= bus;
      if (bwa)      b <= bus;
      if (outregwa) outr <= bus;
      if (pcjmp)      pc <= bus[3:0];
      else if (pcinc) pc <= pc + 4'h1;
   end

   task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] t, input logic h, input logic [15:0] s, input string tag);
      exp_t e;
      e.v   = {t, h, s};
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic push_instr(input logic [3:0] op, input logic cond, input string name);
      logic [15:0] e2, e3, e4;
      int n;
      e2 = 16'h0; e3 = 16'h0; e4 = 16'h0; n = 5;
      case (op)
         4'h1: begin e2 = INREGOA | MARWA; e3 = RAMOA | AWA; n = 4; end
         4'h2: begin e2 = INREGOA | MARWA; e3 = RAMOA | BWA; e4 = SUMOUT | AWA | FLAGSIN; end
         4'h7: begin if (cond) e2 = INREGOA | PCJMP; n = 3; end
         4'hE: begin e2 = AOA | OUTREGWA; n = 3; end
         default: n = 3;
      endcase
`ifndef CU_EARLY_RETURN_EN
      n = 5;
`endif
      push(3'd0, 1'b0, PCOE | MARWA, {name, "_T0"});
      push(3'd1, 1'b0, RAMOA | INREGWA | PCINC, {name, "_T1"});
      push(3'd2, 1'b0, e2, {name, "_T2"});
      if (n > 3) push(3'd3, 1'b0, e3, {name, "_T3"});
      if (n > 4) push(3'd4, 1'b0, e4, {name, "_T4"});
   endtask

   task automatic run_n(input int n);
      exp_t e;
      for (int i = 0; i < n && sb.size() > 0; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         chk(e.tag, {tstate, halt, strobes}, e.v);
      end
   endtask

   task automatic run_all();
      run_n(sb.size());
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      clr = 1'b0; cf = 1'b0; zf = 1'b0; use_rnd = 1'b1; rnd_op = 4'h0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         rnd_op = 4'($urandom);
         cf     = 1'($urandom);
         zf     = 1'($urandom);
         #1 chk("reset_outputs", {tstate, halt, strobes}, 20'h0);
      end
      use_rnd = 1'b0; cf = 1'b0; zf = 1'b0;
      @(negedge clk);
      clr = 1'b1;

      push_instr(4'h1, 1'b0, "lda");
      run_all();
      push_instr(4'h2, 1'b0, "add");
      run_n(1);
      chk("lda_a", 20'(a), 20'h38);
      run_all();
      push_instr(4'hE, 1'b0, "out");
      run_n(1);
      chk("add_a", 20'(a), 20'h5B);
      chk("add_b", 20'(b), 20'h23);
      run_all();
      push_instr(4'h7, 1'b0, "jc_nc");
      run_n(1);
      chk("out_reg", 20'(outr), 20'h5B);
      chk("jc_fetch_pc", 20'(pc), 20'h3);
      run_all();
      cf = 1'b1;
      push_instr(4'h7, 1'b1, "jc_c3");
      run_n(1);
      chk("jc_nc_pc", 20'(pc), 20'h4);
      run_all();
      push_instr(4'h7, 1'b1, "jc_c6");
      run_n(1);
      chk("jc_c3_pc", 20'(pc), 20'h3);
      run_all();
      cf = 1'b0;

      push(3'd0, 1'b0, PCOE | MARWA, "hlt_T0");
      push(3'd1, 1'b0, RAMOA | INREGWA | PCINC, "hlt_T1");
      push(3'd2, 1'b0, 16'h0, "hlt_T2");
      for (int i = 0; i < 20; i++) push(3'd2, 1'b1, 16'h0, "halted");
      run_n(1);
      chk("jc_c6_pc", 20'(pc), 20'h6);
      run_all();

      #1 clr = 1'b0;
      #1 chk("clr_pulse", {tstate, halt, strobes}, 20'h0);
      @(negedge clk);
      clr = 1'b1;

      push(3'd0, 1'b0, PCOE | MARWA, "abort_T0");
      push(3'd1, 1'b0, RAMOA | INREGWA | PCINC, "abort_T1");
      push(3'd2, 1'b0, INREGOA | MARWA, "abort_T2");
      push(3'd3, 1'b0, RAMOA | BWA, "abort_T3");
      run_all();
      #1 clr = 1'b0;
      #1 chk("abort_outputs", {tstate, halt, strobes}, 20'h0);
      repeat (3) @(negedge clk);
      chk("abort_a", 20'(a), 20'h5B);
      chk("abort_b", 20'(b), 20'h23);
      clr = 1'b1;

      push_instr(4'h0, 1'b0, "nop");
      run_n(1);
      chk("abort_pc", 20'(pc), 20'h8);
      run_all();
      chk("nop_pc", 20'(pc), 20'h9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
